// File: rtl/cdb_writeback_arbiter.sv
// Common data bus front end: two per-source FIFOs (RS, LSB), one registered broadcast per enabled cycle.
// Latency: push at edge E broadcasts after E+1 at the earliest. Backpressure: ready drops when a FIFO is full.
module cdb_writeback_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int ROB_WIDTH  = 4,
  parameter int FIFO_WIDTH = 2
) (
  input  logic                  clk_in,
  input  logic                  rst_n_in,
  input  logic                  rdy_in,
  input  logic                  flush_in,
  input  logic                  rs_valid_in,
  output logic                  rs_ready_out,
  input  logic [ROB_WIDTH-1:0]  rs_rob_index_in,
  input  logic [31:0]           rs_value_in,
  input  logic [ADDR_WIDTH-1:0] rs_next_pc_in,
  input  logic                  lsb_valid_in,
  output logic                  lsb_ready_out,
  input  logic [ROB_WIDTH-1:0]  lsb_rob_index_in,
  input  logic [31:0]           lsb_value_in,
  output logic                  cdb_en_out,
  output logic [ROB_WIDTH-1:0]  cdb_rob_index_out,
  output logic [31:0]           cdb_value_out,
  output logic [ADDR_WIDTH-1:0] cdb_next_pc_out,
  output logic                  cdb_src_out
);
  localparam int DEPTH = 1 << FIFO_WIDTH;
  localparam logic [FIFO_WIDTH:0]   FULL_CNT = (FIFO_WIDTH+1)'(DEPTH);
  localparam logic [FIFO_WIDTH:0]   CNT_ONE  = (FIFO_WIDTH+1)'(1);
  localparam logic [FIFO_WIDTH-1:0] PTR_ONE  = FIFO_WIDTH'(1);

  typedef struct packed {
    logic [ROB_WIDTH-1:0]  rob;
    logic [31:0]           value;
    logic [ADDR_WIDTH-1:0] next_pc;
  } entry_t;

  entry_t rs_mem  [DEPTH];
  entry_t lsb_mem [DEPTH];

  logic [FIFO_WIDTH-1:0] rs_head, rs_tail, lsb_head, lsb_tail;
  logic [FIFO_WIDTH:0]   rs_cnt, lsb_cnt;
  logic                  last_grant_lsb;

  logic   rs_push, lsb_push, rs_ne, lsb_ne, grant_rs, grant_lsb, active, pop_rs, pop_lsb;
  entry_t rs_head_e, lsb_head_e;

  // Ready looks only at the registered count, so a full FIFO stays not-ready on a pop cycle.
  assign rs_ready_out  = rdy_in && (rs_cnt  != FULL_CNT);
  assign lsb_ready_out = rdy_in && (lsb_cnt != FULL_CNT);

  assign rs_push  = rs_valid_in  && rs_ready_out  && !flush_in;
  assign lsb_push = lsb_valid_in && lsb_ready_out && !flush_in;

  assign rs_ne     = (rs_cnt  != '0);
  assign lsb_ne    = (lsb_cnt != '0);
  assign grant_rs  = rs_ne && (!lsb_ne || last_grant_lsb);
  assign grant_lsb = lsb_ne && !grant_rs;
  assign active    = rdy_in && !flush_in;
  assign pop_rs    = active && grant_rs;
  assign pop_lsb   = active && grant_lsb;

  assign rs_head_e  = rs_mem[rs_head];
  assign lsb_head_e = lsb_mem[lsb_head];

  always_ff @(posedge clk_in) begin
    if (rs_push)  rs_mem[rs_tail]   <= '{rs_rob_index_in, rs_value_in, rs_next_pc_in};
    if (lsb_push) lsb_mem[lsb_tail] <= '{lsb_rob_index_in, lsb_value_in, '0};
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      rs_head           <= '0;
      rs_tail           <= '0;
      rs_cnt            <= '0;
      lsb_head          <= '0;
      lsb_tail          <= '0;
      lsb_cnt           <= '0;
      last_grant_lsb    <= 1'b1;
      cdb_en_out        <= 1'b0;
      cdb_rob_index_out <= '0;
      cdb_value_out     <= '0;
      cdb_next_pc_out   <= '0;
      cdb_src_out       <= 1'b0;
    end else if (rdy_in) begin
      if (flush_in) begin
        rs_head    <= '0;
        rs_tail    <= '0;
        rs_cnt     <= '0;
        lsb_head   <= '0;
        lsb_tail   <= '0;
        lsb_cnt    <= '0;
        cdb_en_out <= 1'b0;
      end else begin
        if (rs_push)  rs_tail  <= rs_tail  + PTR_ONE;
        if (pop_rs)   rs_head  <= rs_head  + PTR_ONE;
        if (lsb_push) lsb_tail <= lsb_tail + PTR_ONE;
        if (pop_lsb)  lsb_head <= lsb_head + PTR_ONE;

        case ({rs_push, pop_rs})
          2'b10:   rs_cnt <= rs_cnt + CNT_ONE;
          2'b01:   rs_cnt <= rs_cnt - CNT_ONE;
          default: ;
        endcase
        case ({lsb_push, pop_lsb})
          2'b10:   lsb_cnt <= lsb_cnt + CNT_ONE;
          2'b01:   lsb_cnt <= lsb_cnt - CNT_ONE;
          default: ;
        endcase

        // Idle cycles clear only the valid bit; the payload keeps its last value.
        if (pop_rs) begin
          cdb_en_out        <= 1'b1;
          cdb_rob_index_out <= rs_head_e.rob;
          cdb_value_out     <= rs_head_e.value;
          cdb_next_pc_out   <= rs_head_e.next_pc;
          cdb_src_out       <= 1'b0;
          last_grant_lsb    <= 1'b0;
        end else if (pop_lsb) begin
          cdb_en_out        <= 1'b1;
          cdb_rob_index_out <= lsb_head_e.rob;
          cdb_value_out     <= lsb_head_e.value;
          cdb_next_pc_out   <= lsb_head_e.next_pc;
          cdb_src_out       <= 1'b1;
          last_grant_lsb    <= 1'b1;
        end else begin
          cdb_en_out <= 1'b0;
        end
      end
    end
  end
endmodule

// File: tb/tb_cdb_writeback_arbiter.sv
// Randomised and directed stimulus against a queue-based reference model of the CDB arbiter.
module tb_cdb_writeback_arbiter;
  logic        clk_in = 1'b0;
  logic        rst_n_in, rdy_in, flush_in;
  logic        rs_valid_in, rs_ready_out;
  logic [3:0]  rs_rob_index_in;
  logic [31:0] rs_value_in, rs_next_pc_in;
  logic        lsb_valid_in, lsb_ready_out;
  logic [3:0]  lsb_rob_index_in;
  logic [31:0] lsb_value_in;
  logic        cdb_en_out;
  logic [3:0]  cdb_rob_index_out;
  logic [31:0] cdb_value_out, cdb_next_pc_out;
  logic        cdb_src_out;

  always #5 clk_in = ~clk_in;

  cdb_writeback_arbiter dut (
    .clk_in(clk_in), .rst_n_in(rst_n_in), .rdy_in(rdy_in), .flush_in(flush_in),
    .rs_valid_in(rs_valid_in), .rs_ready_out(rs_ready_out),
    .rs_rob_index_in(rs_rob_index_in), .rs_value_in(rs_value_in), .rs_next_pc_in(rs_next_pc_in),
    .lsb_valid_in(lsb_valid_in), .lsb_ready_out(lsb_ready_out),
    .lsb_rob_index_in(lsb_rob_index_in), .lsb_value_in(lsb_value_in),
    .cdb_en_out(cdb_en_out), .cdb_rob_index_out(cdb_rob_index_out), .cdb_value_out(cdb_value_out),
    .cdb_next_pc_out(cdb_next_pc_out), .cdb_src_out(cdb_src_out)
  );

  typedef struct {
    logic [3:0]  rob;
    logic [31:0] val;
    logic [31:0] pc;
  } ent_t;

  ent_t        rs_q[$];
  ent_t        lsb_q[$];
  bit          m_last_lsb;
  logic        m_en, m_src;
  logic [3:0]  m_rob;
  logic [31:0] m_val, m_pc;
  int          n_vec = 0;
  int          n_err = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    rs_q.delete();
    lsb_q.delete();
    m_last_lsb = 1'b1;
    m_en = 0; m_src = 0; m_rob = 0; m_val = 0; m_pc = 0;
  endtask

  task automatic check_outputs();
    chk("cdb_en",  cdb_en_out,        m_en);
    chk("cdb_rob", cdb_rob_index_out, m_rob);
    chk("cdb_val", cdb_value_out,     m_val);
    chk("cdb_pc",  cdb_next_pc_out,   m_pc);
    chk("cdb_src", cdb_src_out,       m_src);
  endtask

  // One clock: drive at negedge, check readies, advance the model, check outputs after posedge.
  task automatic cycle(input bit rv, input logic [3:0] rr, input logic [31:0] rval, input logic [31:0] rpc,
                       input bit lv, input logic [3:0] lr, input logic [31:0] lval,
                       input bit rdy, input bit fl);
    bit   rs_room, lsb_room;
    int   g;
    ent_t e;
    @(negedge clk_in);
    rdy_in = rdy; flush_in = fl;
    rs_valid_in = rv;  rs_rob_index_in = rr;  rs_value_in = rval; rs_next_pc_in = rpc;
    lsb_valid_in = lv; lsb_rob_index_in = lr; lsb_value_in = lval;
    #1;
    rs_room  = rs_q.size()  < 4;
    lsb_room = lsb_q.size() < 4;
    chk("rs_ready",  rs_ready_out,  rdy && rs_room);
    chk("lsb_ready", lsb_ready_out, rdy && lsb_room);
    if (rdy && fl) begin
      rs_q.delete();
      lsb_q.delete();
      m_en = 0;
    end else if (rdy) begin
      g = 0;
      if (rs_q.size() > 0 && lsb_q.size() > 0) g = m_last_lsb ? 1 : 2;
      else if (rs_q.size() > 0)                g = 1;
      else if (lsb_q.size() > 0)               g = 2;
      if (g == 0) m_en = 0;
      else begin
        e = (g == 1) ? rs_q.pop_front() : lsb_q.pop_front();
        m_en = 1; m_rob = e.rob; m_val = e.val; m_pc = e.pc;
        m_src = (g == 2); m_last_lsb = (g == 2);
      end
      if (rv && rs_room)  rs_q.push_back('{rr, rval, rpc});
      if (lv && lsb_room) lsb_q.push_back('{lr, lval, 32'h0});
    end
    @(posedge clk_in);
    #1;
    check_outputs();
  endtask

  task automatic idle();
    cycle(0, 0, 0, 0, 0, 0, 0, 1, 0);
  endtask

  task automatic do_reset();
    @(negedge clk_in);
    rst_n_in = 0; rdy_in = 1; flush_in = 0; rs_valid_in = 0; lsb_valid_in = 0;
    #1;
    model_reset();
    check_outputs();
    @(negedge clk_in);
    rst_n_in = 1;
    #1;
    chk("rst_rs_ready",  rs_ready_out,  1'b1);
    chk("rst_lsb_ready", lsb_ready_out, 1'b1);
  endtask

  initial begin
    rst_n_in = 0; rdy_in = 1; flush_in = 0;
    rs_valid_in = 0; rs_rob_index_in = 0; rs_value_in = 0; rs_next_pc_in = 0;
    lsb_valid_in = 0; lsb_rob_index_in = 0; lsb_value_in = 0;
    model_reset();
    do_reset();

    // Single RS result: visible for exactly one cycle after E+1.
    cycle(1, 4'd3, 32'h1234, 32'h100, 0, 0, 0, 1, 0);
    chk("single_e_en", cdb_en_out, 1'b0);
    idle();
    chk("single_en",  cdb_en_out,        1'b1);
    chk("single_rob", cdb_rob_index_out, 4'd3);
    chk("single_val", cdb_value_out,     32'h1234);
    chk("single_pc",  cdb_next_pc_out,   32'h100);
    chk("single_src", cdb_src_out,       1'b0);
    idle();
    chk("single_after_en", cdb_en_out, 1'b0);

    // Simultaneous push after reset: RS wins the first tie.
    do_reset();
    cycle(1, 4'd1, 32'hAAAA, 32'h200, 1, 4'd2, 32'hBBBB, 1, 0);
    idle();
    chk("tie_first_src", cdb_src_out, 1'b0);
    chk("tie_first_rob", cdb_rob_index_out, 4'd1);
    idle();
    chk("tie_second_src", cdb_src_out, 1'b1);
    chk("tie_second_rob", cdb_rob_index_out, 4'd2);
    chk("tie_second_pc",  cdb_next_pc_out, 32'h0);
    idle();

    // Sustained dual load: fills both FIFOs, exercises wrap and alternation.
    for (int i = 0; i < 20; i++)
      cycle(1, 4'(i), $urandom, $urandom, 1, 4'(i + 8), $urandom, 1, 0);
    // Freeze with LSB still offering: readies low, outputs hold.
    for (int i = 0; i < 3; i++)
      cycle(0, 0, 0, 0, 1, 4'hF, $urandom, 0, 0);
    chk("bp_lsb_ready_frozen", lsb_ready_out, 1'b0);
    for (int i = 0; i < 10; i++) idle();

    // Flush with buffered entries and a push in flight.
    for (int i = 0; i < 3; i++)
      cycle(1, 4'(i), $urandom, $urandom, 1, 4'(i + 4), $urandom, 1, 0);
    cycle(1, 4'd9, 32'h99, 32'h99, 0, 0, 0, 1, 1);
    chk("flush_en", cdb_en_out, 1'b0);
    cycle(1, 4'd7, 32'h7777, 32'h700, 0, 0, 0, 1, 0);
    chk("flush_post_en", cdb_en_out, 1'b0);
    idle();
    chk("flush_r7_en",  cdb_en_out, 1'b1);
    chk("flush_r7_rob", cdb_rob_index_out, 4'd7);
    idle();
    chk("flush_quiet_en", cdb_en_out, 1'b0);

    // Reset asserted between edges while a broadcast is live.
    cycle(1, 4'd5, 32'h5555, 32'h500, 1, 4'd6, 32'h6666, 1, 0);
    idle();
    chk("pre_rst_en", cdb_en_out, 1'b1);
    #2 rst_n_in = 0;
    #1;
    chk("arst_en",  cdb_en_out, 1'b0);
    chk("arst_rob", cdb_rob_index_out, 4'd0);
    chk("arst_val", cdb_value_out, 32'd0);
    chk("arst_pc",  cdb_next_pc_out, 32'd0);
    chk("arst_src", cdb_src_out, 1'b0);
    model_reset();
    @(negedge clk_in);
    rst_n_in = 1; rs_valid_in = 0; lsb_valid_in = 0;
    #1;
    chk("arst_rs_ready",  rs_ready_out,  1'b1);
    chk("arst_lsb_ready", lsb_ready_out, 1'b1);
    idle();

    // Random traffic.
    for (int i = 0; i < 1500; i++)
      cycle($urandom_range(0, 3) != 0, 4'($urandom), $urandom, $urandom,
            $urandom_range(0, 3) != 0, 4'($urandom), $urandom,
            $urandom_range(0, 9) != 0, $urandom_range(0, 31) == 0);
    for (int i = 0; i < 10; i++) idle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
